// File: rtl/pattern_seq_detector.sv
// Pattern sequence detector: locks onto a PAT_LEN-symbol pattern and reports
// when n consecutive error-free patterns have been seen (one-shot or continuous).
module pattern_seq_detector #(
    parameter int unsigned SYM_W   = 8,
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [SYM_W-1:0]         sym_in,
    input  logic [SYM_W*PAT_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]         n,
    input  logic                     mode,
    output logic                     pattern_valid,
    output logic                     locked,
    output logic [CNT_W-1:0]         seq_count,
    output logic [CNT_W-1:0]         err_count
);

    localparam int unsigned IDX_W = $clog2(PAT_LEN);
    localparam int unsigned PAT_W = SYM_W * PAT_LEN;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [CNT_W-1:0]   seq_nx, err_nx;
    logic               pulse;
    logic               valid_nx, locked_nx;

    logic [PAT_W-1:0]   pat_sh;
    logic [CNT_W-1:0]   n_sh;
    logic               mode_sh;

    logic [SYM_W-1:0]   cur_sym;
    logic [CNT_W-1:0]   seq_inc;
    logic [CNT_W-1:0]   n_eff;
    logic               hunt_hit, trk_sym0;

    // n = 0 behaves as 1
    assign n_eff    = (n == '0) ? CNT_W'(1) : n;
    assign seq_inc  = seq_count + CNT_W'(1);
    assign hunt_hit = (sym_in == pattern[SYM_W-1:0]);
    assign trk_sym0 = (sym_in == pat_sh[SYM_W-1:0]);

    // Expected symbol at the current position of the tracked pattern
    always_comb begin
        cur_sym = pat_sh[SYM_W-1:0];
        for (int unsigned k = 0; k < PAT_LEN; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_sym = pat_sh[k*SYM_W +: SYM_W];
            end
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            idx       <= '0;
            seq_count <= '0;
            err_count <= '0;
            pat_sh    <= '0;
            n_sh      <= CNT_W'(1);
            mode_sh   <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            seq_count <= seq_nx;
            err_count <= err_nx;
            // Configuration is only sampled while hunting; frozen once locked
            if (state == HUNT) begin
                pat_sh  <= pattern;
                n_sh    <= n_eff;
                mode_sh <= mode;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        seq_nx   = seq_count;
        err_nx   = err_count;
        pulse    = 1'b0;
        if (enable) begin
            unique case (state)
                HUNT: begin
                    if (hunt_hit) begin
                        state_nx = TRACK;
                        idx_nx   = IDX_W'(1);
                    end
                end
                TRACK: begin
                    if (sym_in == cur_sym) begin
                        if (idx == IDX_W'(PAT_LEN - 1)) begin
                            idx_nx = '0;
                            if (seq_inc == n_sh) begin
                                if (mode_sh) begin
                                    pulse  = 1'b1;
                                    seq_nx = '0;
                                end else begin
                                    state_nx = DONE;
                                    seq_nx   = seq_inc;
                                end
                            end else begin
                                seq_nx = seq_inc;
                            end
                        end else begin
                            idx_nx = idx + IDX_W'(1);
                        end
                    end else begin
                        if (err_count != '1) begin
                            err_nx = err_count + CNT_W'(1);
                        end
                        seq_nx = '0;
                        // A mismatching symbol may itself start a new pattern
                        if (trk_sym0) begin
                            idx_nx = IDX_W'(1);
                        end else begin
                            state_nx = HUNT;
                            idx_nx   = '0;
                        end
                    end
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = HUNT;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Output decode (registered below)
    always_comb begin
        valid_nx  = 1'b0;
        locked_nx = 1'b0;
        valid_nx  = (state_nx == DONE) || pulse;
        locked_nx = (state_nx != HUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_valid <= 1'b0;
            locked        <= 1'b0;
        end else begin
            pattern_valid <= valid_nx;
            locked        <= locked_nx;
        end
    end

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed bench for pattern_seq_detector: expected outputs are queued with
// each driven step and popped/checked one cycle later.
module tb_pattern_seq_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  sym_in;
    logic [31:0] pattern;
    logic [7:0]  n;
    logic        mode;
    logic        pattern_valid;
    logic        locked;
    logic [7:0]  seq_count;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic       v;
        logic       l;
        logic [7:0] s;
        logic [7:0] e;
    } exp_t;

    exp_t exp_q[$];

    pattern_seq_detector #(.SYM_W(8), .PAT_LEN(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sym_in        (sym_in),
        .pattern       (pattern),
        .n             (n),
        .mode          (mode),
        .pattern_valid (pattern_valid),
        .locked        (locked),
        .seq_count     (seq_count),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, check after the edge
    task automatic step(input string tag, input logic r, input logic en, input logic [7:0] s,
                        input logic ev, input logic el, input logic [7:0] es, input logic [7:0] ee);
        exp_t x;
        rst    = r;
        enable = en;
        sym_in = s;
        x.tag = tag; x.v = ev; x.l = el; x.s = es; x.e = ee;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk({x.tag, ".valid"},  {7'd0, pattern_valid}, {7'd0, x.v});
        chk({x.tag, ".locked"}, {7'd0, locked},        {7'd0, x.l});
        chk({x.tag, ".seq"},    seq_count,             x.s);
        chk({x.tag, ".err"},    err_count,             x.e);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        logic [7:0] exp_err;
        rst = 1'b1; enable = 1'b0; sym_in = 8'h00;
        pattern = 32'hDDCCBBAA; n = 8'd2; mode = 1'b0;
        @(posedge clk); #1;

        do_reset("rst0");
        step("hunt_en_low", 0, 0, 8'hAA, 0, 0, 0, 0);
        step("hunt_other",  0, 1, 8'h12, 0, 0, 0, 0);

        // Two clean patterns, one-shot
        step("p1_aa", 0, 1, 8'hAA, 0, 1, 0, 0);
        step("p1_bb", 0, 1, 8'hBB, 0, 1, 0, 0);
        step("p1_cc", 0, 1, 8'hCC, 0, 1, 0, 0);
        step("p1_dd", 0, 1, 8'hDD, 0, 1, 1, 0);
        step("p2_aa", 0, 1, 8'hAA, 0, 1, 1, 0);
        step("p2_bb", 0, 1, 8'hBB, 0, 1, 1, 0);
        step("p2_cc", 0, 1, 8'hCC, 0, 1, 1, 0);
        step("p2_dd", 0, 1, 8'hDD, 1, 1, 2, 0);
        pattern = 32'h11111111;
        step("done_hold1", 0, 1, 8'h55, 1, 1, 2, 0);
        step("done_hold2", 0, 1, 8'h11, 1, 1, 2, 0);
        do_reset("rst_done");
        pattern = 32'hDDCCBBAA;

        // Mismatch then relock
        step("m_aa",  0, 1, 8'hAA, 0, 1, 0, 0);
        step("m_bb",  0, 1, 8'hBB, 0, 1, 0, 0);
        step("m_55",  0, 1, 8'h55, 0, 0, 0, 1);
        step("m_aa2", 0, 1, 8'hAA, 0, 1, 0, 1);
        step("m_bb2", 0, 1, 8'hBB, 0, 1, 0, 1);
        step("m_cc2", 0, 1, 8'hCC, 0, 1, 0, 1);
        step("m_dd2", 0, 1, 8'hDD, 0, 1, 1, 1);
        step("m_aa3", 0, 1, 8'hAA, 0, 1, 1, 1);
        step("m_bb3", 0, 1, 8'hBB, 0, 1, 1, 1);
        step("m_cc3", 0, 1, 8'hCC, 0, 1, 1, 1);
        step("m_dd3", 0, 1, 8'hDD, 1, 1, 2, 1);
        do_reset("rst_m");

        // Mismatch that is symbol 0 stays locked; mismatch on final symbol
        step("s_aa",   0, 1, 8'hAA, 0, 1, 0, 0);
        step("s_bb",   0, 1, 8'hBB, 0, 1, 0, 0);
        step("s_aa_x", 0, 1, 8'hAA, 0, 1, 0, 1);
        step("s_bb2",  0, 1, 8'hBB, 0, 1, 0, 1);
        step("s_cc2",  0, 1, 8'hCC, 0, 1, 0, 1);
        step("s_dd2",  0, 1, 8'hDD, 0, 1, 1, 1);
        step("f_aa",   0, 1, 8'hAA, 0, 1, 1, 1);
        step("f_bb",   0, 1, 8'hBB, 0, 1, 1, 1);
        step("f_cc",   0, 1, 8'hCC, 0, 1, 1, 1);
        step("f_77",   0, 1, 8'h77, 0, 0, 0, 2);
        do_reset("rst_f");

        // Continuous mode, n=1; live config changes after lock are ignored
        n = 8'd1; mode = 1'b1;
        step("c_hunt", 0, 1, 8'h00, 0, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            step($sformatf("c%0d_aa", p), 0, 1, 8'hAA, 0, 1, 0, 0);
            if (p == 0) begin
                n = 8'd3; mode = 1'b0;
            end
            step($sformatf("c%0d_bb", p), 0, 1, 8'hBB, 0, 1, 0, 0);
            step($sformatf("c%0d_cc", p), 0, 1, 8'hCC, 0, 1, 0, 0);
            step($sformatf("c%0d_dd", p), 0, 1, 8'hDD, 1, 1, 0, 0);
        end
        step("c_pulse_end_en_low", 0, 0, 8'hAA, 0, 1, 0, 0);
        step("c_en_low2",          0, 0, 8'h99, 0, 1, 0, 0);
        do_reset("rst_c");

        // Enable low mid-pattern freezes everything
        n = 8'd1; mode = 1'b0;
        step("e_hunt", 0, 1, 8'h00, 0, 0, 0, 0);
        step("e_aa",   0, 1, 8'hAA, 0, 1, 0, 0);
        step("e_bb",   0, 1, 8'hBB, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("e_low%0d", i), 0, 0, 8'h11, 0, 1, 0, 0);
        end
        step("e_cc", 0, 1, 8'hCC, 0, 1, 0, 0);
        step("e_dd", 0, 1, 8'hDD, 1, 1, 1, 0);

        // Reset mid-TRACK (idx=2), overriding enable
        do_reset("rst_e");
        n = 8'd2;
        step("r_hunt", 0, 1, 8'h00, 0, 0, 0, 0);
        step("r_aa",   0, 1, 8'hAA, 0, 1, 0, 0);
        step("r_bb",   0, 1, 8'hBB, 0, 1, 0, 0);
        step("rst_mid", 1, 1, 8'hCC, 0, 0, 0, 0);

        // n = 0 acts as 1
        n = 8'd0;
        step("z_hunt", 0, 1, 8'h00, 0, 0, 0, 0);
        step("z_aa",   0, 1, 8'hAA, 0, 1, 0, 0);
        step("z_bb",   0, 1, 8'hBB, 0, 1, 0, 0);
        step("z_cc",   0, 1, 8'hCC, 0, 1, 0, 0);
        step("z_dd",   0, 1, 8'hDD, 1, 1, 1, 0);
        do_reset("rst_z");

        // Error counter saturation: repeated symbol 0 mismatches keep lock
        n = 8'd2;
        step("sat_hunt", 0, 1, 8'h00, 0, 0, 0, 0);
        step("sat_lock", 0, 1, 8'hAA, 0, 1, 0, 0);
        exp_err = 8'd0;
        for (int k = 1; k <= 260; k++) begin
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
            step($sformatf("sat%0d", k), 0, 1, 8'hAA, 0, 1, 0, exp_err);
        end
        step("sat_hunt_noinc", 0, 1, 8'h55, 0, 0, 0, 8'hFF);
        step("sat_hunt_stay",  0, 1, 8'h55, 0, 0, 0, 8'hFF);
        do_reset("rst_sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
